// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] insAddr,
   input  logic [31:0] ins,
   output logic        if_id_valid,
   output logic [31:0] if_id_ins,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_npc,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      ACT_REDIRECT,
      ACT_FLUSH,
      ACT_STALL,
      ACT_ADVANCE
   } action_e;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   action_e     action;
   logic [31:0] pc_q,          pc_d;
   logic        valid_q,       valid_d;
   logic [31:0] ins_q,         ins_d;
   logic [31:0] id_pc_q,       id_pc_d;
   logic [31:0] id_npc_q,      id_npc_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // Priority among the pipeline controls: redirect > flush > stall > advance.
   always_comb begin
      if (redirect)   action = ACT_REDIRECT;
      else if (flush) action = ACT_FLUSH;
      else if (stall) action = ACT_STALL;
      else            action = ACT_ADVANCE;
   end

   always_comb begin
      // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
      pc_d          = pc_q;
      valid_d       = valid_q;
      ins_d         = ins_q;
      id_pc_d       = id_pc_q;
      id_npc_d      = id_npc_q;
      fetch_count_d = fetch_count_q;
      unique case (action)
         ACT_REDIRECT: begin
            // Misaligned targets are silently aligned rather than faulted.
            pc_d    = redirect_pc & ALIGN_MASK;
            valid_d = 1'b0;
            ins_d   = NOP_INS;
         end
         ACT_FLUSH: begin
            valid_d = 1'b0;
            ins_d   = NOP_INS;
         end
         ACT_STALL: ;
         ACT_ADVANCE: begin
            pc_d          = pc_plus4;
            valid_d       = 1'b1;
            ins_d         = ins;
            id_pc_d       = pc_q;
            id_npc_d      = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC & ALIGN_MASK;
         valid_q       <= 1'b0;
         ins_q         <= NOP_INS;
         id_pc_q       <= 32'h0;
         id_npc_q      <= 32'h0;
         fetch_count_q <= 32'h0;
      end else begin
         pc_q          <= pc_d;
         valid_q       <= valid_d;
         ins_q         <= ins_d;
         id_pc_q       <= id_pc_d;
         id_npc_q      <= id_npc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign insAddr     = pc_q;
   assign if_id_valid = valid_q;
   assign if_id_ins   = ins_q;
   assign if_id_pc    = id_pc_q;
   assign if_id_npc   = id_npc_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized control
// traffic compared against a behavioural fetch model.
module tb_ifetch_unit;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst, stall, flush, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] insAddr, ins;
   logic        if_id_valid;
   logic [31:0] if_id_ins, if_id_pc, if_id_npc, fetch_count;

   logic        rst_b;
   logic        zero_b = 1'b0;
   logic [31:0] rpc_b = 32'h0;
   logic [31:0] addr_b, ins_b;
   logic        valid_b;
   logic [31:0] id_ins_b, id_pc_b, id_npc_b, count_b;

   logic [31:0] mem [0:63];
   assign ins   = mem[insAddr[7:2]];
   assign ins_b = mem[addr_b[7:2]];

   int passed = 0;
   int total  = 0;

   // Behavioural model of the fetch stage.
   logic [31:0] m_pc, m_ins, m_ifpc, m_npc, m_cnt;
   logic        m_valid;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(32'h0), .NOP_INS(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
      .redirect_pc(redirect_pc), .insAddr(insAddr), .ins(ins),
      .if_id_valid(if_id_valid), .if_id_ins(if_id_ins), .if_id_pc(if_id_pc),
      .if_id_npc(if_id_npc), .fetch_count(fetch_count)
   );

   ifetch_unit #(.RESET_PC(WRAP_PC), .NOP_INS(NOP)) dut_wrap (
      .clk(clk), .rst(rst_b), .stall(zero_b), .flush(zero_b), .redirect(zero_b),
      .redirect_pc(rpc_b), .insAddr(addr_b), .ins(ins_b),
      .if_id_valid(valid_b), .if_id_ins(id_ins_b), .if_id_pc(id_pc_b),
      .if_id_npc(id_npc_b), .fetch_count(count_b)
   );

   // Drive one cycle of controls, advance the model, then sample 1 ns after the edge.
   task automatic cycle(input logic r, input logic rd, input logic fl, input logic st,
                        input logic [31:0] rpc);
      rst = r; redirect = rd; flush = fl; stall = st; redirect_pc = rpc;
      if (r) begin
         m_pc = 32'h0; m_valid = 1'b0; m_ins = NOP; m_ifpc = 32'h0; m_npc = 32'h0; m_cnt = 32'h0;
      end else if (rd) begin
         m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_ins = NOP;
      end else if (fl) begin
         m_valid = 1'b0; m_ins = NOP;
      end else if (!st) begin
         m_valid = 1'b1; m_ins = mem[m_pc[7:2]]; m_ifpc = m_pc;
         m_npc = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      cycle(1, 1, 1, 1, 32'h55);
      cycle(1, 0, 0, 0, 32'h0);
      total++; if (insAddr !== 32'h0) $display("FAIL reset_addr: got %h expected %h", insAddr, 32'h0); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if_id_valid); else passed++;
      total++; if (if_id_ins !== NOP) $display("FAIL reset_ins: got %h expected %h", if_id_ins, NOP); else passed++;
      total++; if (if_id_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", if_id_pc); else passed++;
      total++; if (if_id_npc !== 32'h0) $display("FAIL reset_npc: got %h expected 0", if_id_npc); else passed++;
      total++; if (fetch_count !== 32'h0) $display("FAIL reset_count: got %h expected 0", fetch_count); else passed++;
   endtask

   task automatic test_free_run;
      logic [31:0] words [4];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
      for (int i = 0; i < 4; i++) mem[i] = words[i];
      cycle(1, 0, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 0, 32'h0);
         total++; if (insAddr !== 32'(4 * (i + 1))) $display("FAIL run_addr%0d: got %h expected %h", i, insAddr, 32'(4 * (i + 1))); else passed++;
         total++; if (if_id_ins !== words[i]) $display("FAIL run_ins%0d: got %h expected %h", i, if_id_ins, words[i]); else passed++;
         total++; if (if_id_pc !== 32'(4 * i)) $display("FAIL run_pc%0d: got %h expected %h", i, if_id_pc, 32'(4 * i)); else passed++;
         total++; if (if_id_npc !== 32'(4 * i + 4)) $display("FAIL run_npc%0d: got %h expected %h", i, if_id_npc, 32'(4 * i + 4)); else passed++;
         total++; if (if_id_valid !== 1'b1) $display("FAIL run_valid%0d: got %b expected 1", i, if_id_valid); else passed++;
      end
      total++; if (fetch_count !== 32'd4) $display("FAIL run_count: got %0d expected 4", fetch_count); else passed++;
   endtask

   task automatic test_stall;
      cycle(1, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      total++; if (insAddr !== 32'h8) $display("FAIL stall_pre_addr: got %h expected 8", insAddr); else passed++;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 32'h0);
         total++; if (insAddr !== 32'h8) $display("FAIL stall_addr%0d: got %h expected 8", i, insAddr); else passed++;
         total++; if (if_id_pc !== 32'h4 || if_id_ins !== mem[1]) $display("FAIL stall_ifid%0d: got pc %h ins %h expected pc 4 ins %h", i, if_id_pc, if_id_ins, mem[1]); else passed++;
         total++; if (fetch_count !== 32'd2) $display("FAIL stall_count%0d: got %0d expected 2", i, fetch_count); else passed++;
      end
      cycle(0, 0, 0, 0, 32'h0);
      total++; if (if_id_pc !== 32'h8) $display("FAIL stall_release_pc: got %h expected 8", if_id_pc); else passed++;
   endtask

   task automatic test_redirect;
      logic [31:0] cnt_before;
      cnt_before = fetch_count;
      cycle(0, 1, 0, 1, 32'h0000_0043);
      total++; if (insAddr !== 32'h40) $display("FAIL redir_addr: got %h expected 40", insAddr); else passed++;
      total++; if (if_id_valid !== 1'b0 || if_id_ins !== NOP) $display("FAIL redir_bubble: got valid %b ins %h expected valid 0 ins %h", if_id_valid, if_id_ins, NOP); else passed++;
      total++; if (fetch_count !== cnt_before) $display("FAIL redir_count: got %0d expected %0d", fetch_count, cnt_before); else passed++;
      total++; if (if_id_pc !== 32'h8) $display("FAIL redir_pc_hold: got %h expected 8", if_id_pc); else passed++;
      cycle(0, 0, 0, 0, 32'h0);
      total++; if (if_id_pc !== 32'h40 || if_id_ins !== mem[16]) $display("FAIL redir_capture: got pc %h ins %h expected pc 40 ins %h", if_id_pc, if_id_ins, mem[16]); else passed++;
   endtask

   task automatic test_flush;
      cycle(0, 1, 0, 0, 32'h20);
      cycle(0, 0, 0, 0, 32'h0);
      cycle(0, 1, 0, 0, 32'h20);
      cycle(0, 0, 1, 1, 32'h0);
      total++; if (if_id_valid !== 1'b0 || if_id_ins !== NOP) $display("FAIL flush_bubble: got valid %b ins %h expected valid 0 ins %h", if_id_valid, if_id_ins, NOP); else passed++;
      total++; if (insAddr !== 32'h20) $display("FAIL flush_addr: got %h expected 20", insAddr); else passed++;
      cycle(0, 0, 0, 0, 32'h0);
      total++; if (if_id_pc !== 32'h20 || if_id_ins !== mem[8]) $display("FAIL flush_refetch: got pc %h ins %h expected pc 20 ins %h", if_id_pc, if_id_ins, mem[8]); else passed++;
   endtask

   task automatic test_wrap;
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
      exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
      rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      total++; if (addr_b !== exp_addr[0]) $display("FAIL wrap_addr0: got %h expected %h", addr_b, exp_addr[0]); else passed++;
      for (int i = 1; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if (addr_b !== exp_addr[i]) $display("FAIL wrap_addr%0d: got %h expected %h", i, addr_b, exp_addr[i]); else passed++;
         total++; if (id_npc_b !== exp_addr[i]) $display("FAIL wrap_npc%0d: got %h expected %h", i, id_npc_b, exp_addr[i]); else passed++;
      end
      total++; if (count_b !== 32'd3) $display("FAIL wrap_count: got %0d expected 3", count_b); else passed++;
   endtask

   task automatic test_mid_reset;
      cycle(0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 0, 32'h100);
      total++; if (insAddr !== 32'h0) $display("FAIL midrst_addr: got %h expected 0", insAddr); else passed++;
      total++; if (if_id_valid !== 1'b0 || if_id_ins !== NOP) $display("FAIL midrst_ifid: got valid %b ins %h expected valid 0 ins %h", if_id_valid, if_id_ins, NOP); else passed++;
      total++; if (if_id_pc !== 32'h0 || if_id_npc !== 32'h0) $display("FAIL midrst_pcs: got pc %h npc %h expected 0 0", if_id_pc, if_id_npc); else passed++;
      total++; if (fetch_count !== 32'h0) $display("FAIL midrst_count: got %0d expected 0", fetch_count); else passed++;
   endtask

   task automatic test_random;
      logic r, rd, fl, st;
      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 39) == 0);
         rd = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 3) == 0);
         cycle(r, rd, fl, st, $urandom);
         total++;
         if (insAddr !== m_pc || if_id_valid !== m_valid || if_id_ins !== m_ins ||
             if_id_pc !== m_ifpc || if_id_npc !== m_npc || fetch_count !== m_cnt)
            $display("FAIL rand%0d: got addr %h v %b ins %h pc %h npc %h cnt %0d expected addr %h v %b ins %h pc %h npc %h cnt %0d",
                     i, insAddr, if_id_valid, if_id_ins, if_id_pc, if_id_npc, fetch_count,
                     m_pc, m_valid, m_ins, m_ifpc, m_npc, m_cnt);
         else passed++;
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      rst_b = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_flush();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
